// File: rtl/poly_plot_pkg.sv
// Shared types and helpers for the polynomial plot sequencer: state encoding,
// scale-register selector and pacing length per speed setting.
package poly_plot_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned SPEED_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_INIT   = 4'd0,
        S_DEG    = 4'd1,
        S_DEG_W  = 4'd2,
        S_COEF   = 4'd3,
        S_COEF_W = 4'd4,
        S_REQ    = 4'd5,
        S_WAIT   = 4'd6,
        S_PACE   = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    // Coefficient index one past the highest degree addresses the scale register
    function automatic int unsigned scale_sel(input int unsigned max_deg);
        return max_deg + 32'd1;
    endfunction

    // Pacing length 2^(4*(3-speed)+8)-1: speed 3 is fastest
    function automatic int unsigned pace_len(input logic [SPEED_W-1:0] speed);
        int unsigned shift;
        shift = 32'd4 * (32'd3 - 32'(speed)) + 32'd8;
        return (32'd1 << shift) - 32'd1;
    endfunction

endpackage

// File: rtl/poly_plot_sequencer_pace.sv
// Pacing divider: load restarts the count at 1 and latches the limit;
// expired_c is high once the count has reached the limit.
module plot_pace_counter #(
    parameter int unsigned PACE_BITS = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [PACE_BITS-1:0] limit,
    output logic                 expired_c
);

    logic [PACE_BITS-1:0] count_q;
    logic [PACE_BITS-1:0] limit_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            limit_q <= '0;
        end else if (load) begin
            count_q <= PACE_BITS'(1);
            limit_q <= limit;
        end else if (!expired_c) begin
            count_q <= count_q + PACE_BITS'(1);
        end
    end

    assign expired_c = (count_q == limit_q);

endmodule

// File: rtl/poly_plot_sequencer.sv
// Control sequencer for the graphing calculator: screen clear, degree and
// coefficient entry per channel, then a paced x sweep. Define PLOT_HOLD_EN to
// hold in S_DONE until a go press and overlay the next functions without clearing.
module poly_plot_sequencer
    import poly_plot_pkg::*;
#(
    parameter int unsigned MAX_DEG   = 4,
    parameter int unsigned X_MAX     = 320,
    parameter int unsigned X_BITS    = 9,
    parameter int unsigned N_CH      = 2,
    parameter int unsigned PACE_BITS = 20
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   go,
    input  logic [$clog2(MAX_DEG+1)-1:0]           degree,
    input  logic [1:0]                             speed,
    input  logic                                   init_complete,
    input  logic                                   eval_valid,
    input  logic                                   out_of_bounds,
    output logic                                   start_init,
    output logic                                   load_coef,
    output logic [$clog2(MAX_DEG+2)-1:0]           coef_sel,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ch,
    output logic                                   eval_req,
    output logic [X_BITS-1:0]                      x,
    output logic signed [X_BITS:0]                 x_val,
    output logic                                   plot,
    output logic                                   done,
    output logic [3:0]                             state
);

    localparam int unsigned CS_W = $clog2(MAX_DEG + 2);
    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned XV_W = X_BITS + 1;

    localparam logic [CS_W-1:0]   SCALE   = CS_W'(scale_sel(MAX_DEG));
    localparam logic [CS_W-1:0]   DEG_MAX = CS_W'(MAX_DEG);
    localparam logic [CH_W-1:0]   CH_LAST = CH_W'(N_CH - 1);
    localparam logic [X_BITS-1:0] X_LAST  = X_BITS'(X_MAX - 1);
    localparam logic [XV_W-1:0]   X_HALF  = XV_W'(X_MAX / 2);

    state_t                       state_q, state_d;
    logic [CS_W-1:0]              coef_sel_q, coef_sel_d;
    logic [CH_W-1:0]              ch_q, ch_d;
    logic [X_BITS-1:0]            x_q, x_d;
    logic [XV_W-1:0]              x_val_q, x_val_d;
    logic                         eval_req_q, eval_req_d;
    logic                         plot_q, plot_d;
    logic [N_CH-1:0][CS_W-1:0]    deg_q, deg_d;
    logic [CS_W-1:0]              degree_clamped_c;
    logic                         pace_load_c;
    logic                         pace_expired_c;
`ifdef PLOT_HOLD_EN
    logic                         hold_go_q, hold_go_d;
`endif

    always_comb begin
        degree_clamped_c = (32'(degree) > MAX_DEG) ? DEG_MAX : CS_W'(degree);
    end

    // Divider reloads every cycle outside S_PACE, so it runs only while pacing
    assign pace_load_c = (state_q != S_PACE);

    plot_pace_counter #(
        .PACE_BITS (PACE_BITS)
    ) u_pace (
        .clk       (clk),
        .reset     (reset),
        .load      (pace_load_c),
        .limit     (PACE_BITS'(pace_len(speed))),
        .expired_c (pace_expired_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_INIT;
            coef_sel_q <= '0;
            ch_q       <= '0;
            x_q        <= '0;
            x_val_q    <= '0;
            eval_req_q <= 1'b0;
            plot_q     <= 1'b0;
            deg_q      <= '0;
`ifdef PLOT_HOLD_EN
            hold_go_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            coef_sel_q <= coef_sel_d;
            ch_q       <= ch_d;
            x_q        <= x_d;
            x_val_q    <= x_val_d;
            eval_req_q <= eval_req_d;
            plot_q     <= plot_d;
            deg_q      <= deg_d;
`ifdef PLOT_HOLD_EN
            hold_go_q  <= hold_go_d;
`endif
        end
    end

    // Next state and next values of the registered outputs
    always_comb begin
        state_d    = state_q;
        coef_sel_d = coef_sel_q;
        ch_d       = ch_q;
        x_d        = x_q;
        x_val_d    = x_val_q;
        eval_req_d = 1'b0;
        plot_d     = 1'b0;
        deg_d      = deg_q;
`ifdef PLOT_HOLD_EN
        hold_go_d  = hold_go_q;
`endif
        case (state_q)
            S_INIT: begin
                if (init_complete) state_d = S_DEG;
            end
            S_DEG: begin
                if (go) begin
                    deg_d[ch_q] = degree_clamped_c;
                    state_d     = S_DEG_W;
                end
            end
            S_DEG_W: begin
                if (!go) begin
                    coef_sel_d = deg_q[ch_q];
                    state_d    = S_COEF;
                end
            end
            S_COEF: begin
                if (go) state_d = S_COEF_W;
            end
            S_COEF_W: begin
                if (!go) begin
                    if (coef_sel_q == SCALE) begin
                        if (ch_q != CH_LAST) begin
                            ch_d    = ch_q + CH_W'(1);
                            state_d = S_DEG;
                        end else begin
                            ch_d       = '0;
                            x_d        = '0;
                            x_val_d    = XV_W'(0) - X_HALF;
                            eval_req_d = 1'b1;
                            state_d    = S_REQ;
                        end
                    end else if (coef_sel_q != '0) begin
                        coef_sel_d = coef_sel_q - CS_W'(1);
                        state_d    = S_COEF;
                    end else begin
                        coef_sel_d = SCALE;
                        state_d    = S_COEF;
                    end
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eval_valid) begin
                    plot_d  = !out_of_bounds;
                    state_d = S_PACE;
                end
            end
            S_PACE: begin
                if (pace_expired_c) begin
                    if (ch_q != CH_LAST) begin
                        ch_d       = ch_q + CH_W'(1);
                        eval_req_d = 1'b1;
                        state_d    = S_REQ;
                    end else begin
                        ch_d = '0;
                        if (x_q == X_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            x_d        = x_q + X_BITS'(1);
                            x_val_d    = XV_W'(x_q) + XV_W'(1) - X_HALF;
                            eval_req_d = 1'b1;
                            state_d    = S_REQ;
                        end
                    end
                end
            end
            S_DONE: begin
`ifdef PLOT_HOLD_EN
                if (go) begin
                    hold_go_d = 1'b1;
                end else if (hold_go_q) begin
                    hold_go_d = 1'b0;
                    state_d   = S_DEG;
                end
`else
                state_d = S_INIT;
`endif
            end
            default: state_d = S_INIT;
        endcase
    end

    assign start_init = (state_q == S_INIT);
    assign load_coef  = (state_q == S_COEF);
    assign done       = (state_q == S_DONE);
    assign state      = state_q;
    assign coef_sel   = coef_sel_q;
    assign ch         = ch_q;
    assign x          = x_q;
    assign x_val      = $signed(x_val_q);
    assign eval_req   = eval_req_q;
    assign plot       = plot_q;

endmodule

// File: tb/tb_poly_plot_sequencer.sv
// Bench for poly_plot_sequencer: table-driven coefficient entry, randomized
// function-generator responses against a reference sweep, reset abort.
module tb_poly_plot_sequencer;
    import poly_plot_pkg::*;

    localparam int MAX_DEG   = 4;
    localparam int X_MAX     = 40;
    localparam int X_BITS    = 6;
    localparam int N_CH      = 2;
    localparam int SCALE_IDX = MAX_DEG + 1;
    localparam int BUDGET    = 10000;

    logic              clk = 1'b0;
    logic              reset;
    logic              go;
    logic [2:0]        degree;
    logic [1:0]        speed;
    logic              init_complete;
    logic              eval_valid;
    logic              out_of_bounds;
    logic              start_init;
    logic              load_coef;
    logic [2:0]        coef_sel;
    logic [0:0]        ch;
    logic              eval_req;
    logic [X_BITS-1:0] x;
    logic signed [X_BITS:0] x_val;
    logic              plot;
    logic              done;
    logic [3:0]        state;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0] degree;
        int         first_sel;
    } entry_t;

    entry_t frame1 [N_CH];
    entry_t frame2 [N_CH];

    poly_plot_sequencer #(
        .MAX_DEG   (MAX_DEG),
        .X_MAX     (X_MAX),
        .X_BITS    (X_BITS),
        .N_CH      (N_CH),
        .PACE_BITS (20)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .go            (go),
        .degree        (degree),
        .speed         (speed),
        .init_complete (init_complete),
        .eval_valid    (eval_valid),
        .out_of_bounds (out_of_bounds),
        .start_init    (start_init),
        .load_coef     (load_coef),
        .coef_sel      (coef_sel),
        .ch            (ch),
        .eval_req      (eval_req),
        .x             (x),
        .x_val         (x_val),
        .plot          (plot),
        .done          (done),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pace_cycles(input int spd);
        return (1 << (4 * (3 - spd) + 8)) - 1;
    endfunction

    // Degree press plus one press per coefficient from first_sel down to 0, then scale
    task automatic enter_channel(input logic [2:0] deg, input int first_sel, input int exp_ch);
        int e;
        check("deg_state", int'(state), int'(S_DEG));
        check("deg_ch", int'(ch), exp_ch);
        check("deg_load_coef", int'(load_coef), 0);
        degree = deg;
        go = 1'b1;
        tick();
        check("deg_w_state", int'(state), int'(S_DEG_W));
        tick();
        tick();
        check("deg_w_held", int'(state), int'(S_DEG_W));
        go = 1'b0;
        degree = 3'($urandom_range(0, 7));
        tick();
        for (int k = first_sel; k >= -1; k--) begin
            e = (k < 0) ? SCALE_IDX : k;
            check("coef_state", int'(state), int'(S_COEF));
            check("coef_sel", int'(coef_sel), e);
            check("coef_load", int'(load_coef), 1);
            go = 1'b1;
            tick();
            check("coef_w_load", int'(load_coef), 0);
            tick();
            check("coef_w_held", int'(state), int'(S_COEF_W));
            go = 1'b0;
            tick();
        end
    endtask

    // Wait for one eval request, check it, answer after lat cycles, check the strobe
    task automatic serve(input int exp_x, input int exp_ch, input bit oob, input int lat,
                         input int exp_gap, input int spd, output bit got_plot);
        int waited;
        bit stray;
        waited = 0;
        stray  = 1'b0;
        got_plot = 1'b0;
        while (eval_req !== 1'b1 && waited < BUDGET) begin
            if (exp_gap > 0 && waited < exp_gap - 2) begin
                eval_valid    = 1'($urandom_range(0, 1));
                out_of_bounds = 1'($urandom_range(0, 1));
            end else begin
                eval_valid    = 1'b0;
                out_of_bounds = 1'b0;
            end
            tick();
            waited++;
            if (plot) stray = 1'b1;
        end
        eval_valid    = 1'b0;
        out_of_bounds = 1'b0;
        if (eval_req !== 1'b1) begin
            check("req_timeout", waited, exp_gap);
            return;
        end
        if (exp_gap >= 0) check("pace_gap", waited, exp_gap);
        speed = 2'(spd);
        check("req_x", int'(x), exp_x);
        check("req_x_val", int'(x_val), exp_x - X_MAX / 2);
        check("req_ch", int'(ch), exp_ch);
        tick();
        check("wait_state", int'(state), int'(S_WAIT));
        check("req_single", int'(eval_req), 0);
        for (int i = 1; i < lat; i++) begin
            out_of_bounds = 1'($urandom_range(0, 1));
            tick();
            if (plot) stray = 1'b1;
        end
        eval_valid    = 1'b1;
        out_of_bounds = oob;
        tick();
        eval_valid    = 1'b0;
        out_of_bounds = 1'b0;
        got_plot = plot;
        check("plot_strobe", int'(plot), oob ? 0 : 1);
        check("pace_state", int'(state), int'(S_PACE));
        check("stray_plot", int'(stray), 0);
    endtask

    initial begin
        bit got;
        bit oob;
        int exp_plots;
        int got_plots;
        int first_x;
        int waited;
        bit stray;

        frame1[0] = '{3'd7, 4};
        frame1[1] = '{3'd2, 2};
        frame2[0] = '{3'd0, 0};
        frame2[1] = '{3'd5, 4};

        reset = 1'b0;
        go = 1'b0;
        degree = '0;
        speed = 2'd3;
        init_complete = 1'b0;
        eval_valid = 1'b0;
        out_of_bounds = 1'b0;
        repeat (3) tick();

        check("rst_state", int'(state), int'(S_INIT));
        check("rst_start_init", int'(start_init), 1);
        check("rst_x", int'(x), 0);
        check("rst_x_val", int'(x_val), 0);
        check("rst_ch", int'(ch), 0);
        check("rst_plot", int'(plot), 0);
        check("rst_eval_req", int'(eval_req), 0);
        check("rst_done", int'(done), 0);
        check("rst_load_coef", int'(load_coef), 0);
        check("rst_coef_sel", int'(coef_sel), 0);

        #3 reset = 1'b1;
        tick();
        tick();
        check("init_hold", int'(state), int'(S_INIT));
        init_complete = 1'b1;
        tick();
        init_complete = 1'b0;
        check("init_to_deg", int'(state), int'(S_DEG));
        check("deg_start_init", int'(start_init), 0);

        // Frame 1: clamped degree on ch0, full sweep at speed 3
        for (int i = 0; i < N_CH; i++) enter_channel(frame1[i].degree, frame1[i].first_sel, i);
        check("entry_to_req", int'(state), int'(S_REQ));

        exp_plots = 0;
        got_plots = 0;
        first_x   = -1;
        for (int xi = 0; xi < X_MAX; xi++) begin
            for (int c = 0; c < N_CH; c++) begin
                oob = (c == 0) ? (xi < 10) : ($urandom_range(0, 3) == 0);
                serve(xi, c, oob, $urandom_range(1, 3),
                      (xi == 0 && c == 0) ? -1 : pace_cycles(3), 3, got);
                if (!oob) exp_plots++;
                if (got) got_plots++;
                if (got && c == 0 && first_x < 0) first_x = xi;
            end
        end
        check("plot_count", got_plots, exp_plots);
        check("first_plot_x_ch0", first_x, 10);

        waited = 0;
        while (done !== 1'b1 && waited < BUDGET) begin
            tick();
            waited++;
        end
        check("done_gap", waited, pace_cycles(3));
        check("done_state", int'(state), int'(S_DONE));
        check("done_x", int'(x), X_MAX - 1);
        check("done_x_val", int'(x_val), X_MAX - 1 - X_MAX / 2);
`ifdef PLOT_HOLD_EN
        tick();
        tick();
        check("done_hold", int'(done), 1);
        go = 1'b1;
        tick();
        tick();
        check("done_hold_go", int'(done), 1);
        go = 1'b0;
        tick();
        check("hold_to_deg", int'(state), int'(S_DEG));
        check("hold_no_clear", int'(start_init), 0);
        check("hold_done_low", int'(done), 0);
`else
        tick();
        check("done_one_cycle", int'(done), 0);
        check("done_to_init", int'(state), int'(S_INIT));
        check("reclear", int'(start_init), 1);
        init_complete = 1'b1;
        tick();
        init_complete = 1'b0;
`endif

        // Frame 2: one slow pace interval at speed 2, then reset mid-sweep
        for (int i = 0; i < N_CH; i++) enter_channel(frame2[i].degree, frame2[i].first_sel, i);
        serve(0, 0, 1'b0, 1, -1, 2, got);
        serve(0, 1, 1'b0, 2, pace_cycles(2), 3, got);
        for (int xi = 1; xi < 25; xi++) begin
            for (int c = 0; c < N_CH; c++) begin
                serve(xi, c, 1'($urandom_range(0, 1)), $urandom_range(1, 3), pace_cycles(3), 3, got);
            end
        end
        waited = 0;
        while (eval_req !== 1'b1 && waited < BUDGET) begin
            tick();
            waited++;
        end
        check("abort_gap", waited, pace_cycles(3));
        check("abort_x", int'(x), 25);
        tick();
        check("abort_in_wait", int'(state), int'(S_WAIT));
        #2 reset = 1'b0;
        #1;
        check("abort_state", int'(state), int'(S_INIT));
        check("abort_x_clr", int'(x), 0);
        check("abort_plot", int'(plot), 0);
        check("abort_start_init", int'(start_init), 1);
        eval_valid = 1'b1;
        tick();
        eval_valid = 1'b0;
        #3 reset = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (plot || eval_req) stray = 1'b1;
        end
        check("post_rst_state", int'(state), int'(S_INIT));
        check("post_rst_x", int'(x), 0);
        check("post_rst_start_init", int'(start_init), 1);
        check("post_rst_no_plot", int'(stray), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
